// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for rr_mux_arb: default geometry, statistics counter width
// and the channel-index width helper.
package rr_mux_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int N_CH_DEF  = 6;
    localparam int STAT_W    = 16;

    // Channel index width; never narrower than one bit.
    function automatic int sel_w(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Channel-side and output-side handshake bundle of rr_mux_arb.
// master = traffic source/sink, slave = the multiplexer itself.
interface rr_mux_arb_if
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_CH  = N_CH_DEF
);
    localparam int SEL_W = sel_w(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_mux_arb_arbiter.sv
// Round-robin grant: first requester at or above ptr, otherwise the lowest
// requester overall (wrap-around). Output is one-hot or zero.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant
);

    logic [N_CH-1:0] w_upper_req;

    function automatic logic [N_CH-1:0] first_set(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_upper_req = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_upper_req[i] = req[i] & (SEL_W'(i) >= ptr);
        end
    end

    assign grant = (|w_upper_req) ? first_set(w_upper_req) : first_set(req);

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel multiplexer with fixed-select or round-robin arbitration into a
// one-deep output register. Optional per-channel grant counters: RR_MUX_ARB_STATS_EN.
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int N_CH  = N_CH_DEF,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_rr,
    input  logic [SEL_W-1:0]  sel,
    rr_mux_arb_if.slave       bus,
    input  logic [SEL_W-1:0]  stat_sel,
    output logic [STAT_W-1:0] stat_count
);

    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;

    logic             w_accept;
    logic [N_CH-1:0]  w_fix_grant;
    logic [N_CH-1:0]  w_rr_grant;
    logic [N_CH-1:0]  w_grant;
    logic [N_CH-1:0]  w_in_ready;
    logic             w_xfer;
    logic [SEL_W-1:0] w_xfer_ch;
    logic [WIDTH-1:0] w_xfer_data;
    logic [SEL_W-1:0] w_ptr_next;

    rr_arbiter #(.N_CH(N_CH)) u_arbiter (
        .req   (bus.in_valid),
        .ptr   (r_ptr),
        .grant (w_rr_grant)
    );

    // Out-of-range sel matches no channel, so it yields no grant.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_fix_grant[i] = bus.in_valid[i] & (sel == SEL_W'(i));
        end
    end

    assign w_accept   = !r_out_valid || bus.out_ready;
    assign w_grant    = mode_rr ? w_rr_grant : w_fix_grant;
    // rst_n gates the accept path so no channel sees a ready while held in reset.
    assign w_in_ready = (rst_n && w_accept) ? w_grant : '0;
    assign w_xfer     = |w_in_ready;

    always_comb begin
        w_xfer_ch   = '0;
        w_xfer_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_in_ready[i]) begin
                w_xfer_ch = w_xfer_ch | SEL_W'(i);
            end
            w_xfer_data = w_xfer_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_in_ready[i]}});
        end
    end

    assign w_ptr_next = (w_xfer_ch == SEL_W'(N_CH - 1)) ? '0 : w_xfer_ch + 1'b1;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_xfer_data;
            r_out_ch    <= w_xfer_ch;
            r_ptr       <= w_ptr_next;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

`ifdef RR_MUX_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [N_CH];

    // NOTE: the counters form a small register array, not RAM, so they take
    // the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) r_stat[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.in_valid[i] && w_in_ready[i] && (r_stat[i] != '1)) begin
                    r_stat[i] <= r_stat[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (stat_sel == SEL_W'(i)) stat_count = r_stat[i];
        end
    end
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^stat_sel;
    assign stat_count        = '0;
`endif

endmodule
